// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if
//  Bundles the two requester ports (CPU memory path and debug/loader port),
//  the RAM macro side and the arbiter status outputs into one interface.
//  Ports of the bundle:
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, held stable until cpu_ack
//   cpu_ack/cpu_rdata                  CPU completion pulse and read data
//   dbg_*                              same set for the debug/loader port
//   mem_en/mem_we/mem_addr/mem_wdata   RAM command, driven by the arbiter
//   mem_rdata                          RAM read data back to the arbiter
//   busy/owner                         arbiter status (owner: 0 = CPU, 1 = debug)
//  Modports: slave = the arbiter itself, master = whatever surrounds it.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, owner
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//  Shares the single-port program/data RAM between the CPU memory path and a
//  debug/loader port. One transaction at a time; ties are resolved either
//  round-robin (FIXED_PRI=0) or always in favour of the CPU (FIXED_PRI=1).
//  Ports:
//   clock  system clock, rising edge
//   clear  asynchronous active-low reset
//   bus    mem_bus_arbiter_if.slave: requester ports, RAM command/data, busy/owner
//  Transaction flow: IDLE -> ISSUE -> [WAIT x RD_LAT, reads only] -> RESP -> IDLE.
module mem_bus_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic             clock,
    input  logic             clear,
    mem_bus_arbiter_if.slave bus
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              owner_reg, owner_next;
    logic              last_owner_reg, last_owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] dbg_rdata_reg, dbg_rdata_next;
    logic              grant_dbg;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;   // so the CPU wins the first tie
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            cpu_rdata_reg  <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            wdata_reg      <= wdata_next;
            cpu_rdata_reg  <= cpu_rdata_next;
            dbg_rdata_reg  <= dbg_rdata_next;
        end
    end

    always_comb begin
        // Debug wins only when alone, or on a tie in round-robin mode when the
        // CPU was served last.
        grant_dbg       = bus.dbg_req &&
                          (!bus.cpu_req || (FIXED_PRI == 0 && !last_owner_reg));
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        cpu_rdata_next  = cpu_rdata_reg;
        dbg_rdata_next  = dbg_rdata_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cpu_req || bus.dbg_req) begin
                    // The request is captured here; later input changes are ignored.
                    owner_next = grant_dbg;
                    we_next    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
                    addr_next  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                    wdata_next = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (we_reg) begin
                    state_next = RESP;
                end else begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(RD_LAT - 1);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    if (owner_reg) dbg_rdata_next = bus.mem_rdata;
                    else           cpu_rdata_next = bus.mem_rdata;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            RESP: begin
                last_owner_next = owner_reg;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.mem_en    = (state_reg == ISSUE);
    assign bus.mem_we    = (state_reg == ISSUE) && we_reg;
    assign bus.mem_addr  = addr_reg;
    assign bus.mem_wdata = wdata_reg;
    assign bus.cpu_ack   = (state_reg == RESP) && !owner_reg;
    assign bus.dbg_ack   = (state_reg == RESP) && owner_reg;
    assign bus.cpu_rdata = cpu_rdata_reg;
    assign bus.dbg_rdata = dbg_rdata_reg;
    assign bus.busy      = (state_reg != IDLE);
    assign bus.owner     = owner_reg;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 is round-robin, instance 1 fixed CPU
// priority. Each instance has its own RAM and a transaction-level model that
// predicts every output on every falling edge.
module tb_mem_bus_arbiter;
    localparam int AW     = 9;
    localparam int DW     = 32;
    localparam int RD_LAT = 1;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic [1:0]    clear_s, cpu_req_s, cpu_we_s, dbg_req_s, dbg_we_s;
    logic [AW-1:0] cpu_addr_s [2];
    logic [AW-1:0] dbg_addr_s [2];
    logic [DW-1:0] cpu_wdata_s [2];
    logic [DW-1:0] dbg_wdata_s [2];

    logic [1:0]    cpu_ack_w, dbg_ack_w, mem_en_w, mem_we_w, busy_w, owner_w;
    logic [DW-1:0] cpu_rdata_w [2];
    logic [DW-1:0] dbg_rdata_w [2];
    logic [AW-1:0] mem_addr_w [2];
    logic [DW-1:0] mem_wdata_w [2];

    int    checks = 0;
    int    errors = 0;
    string log_s [2];

    function automatic logic [DW-1:0] init_word(input int a);
        if (a == 'h010) return 32'hDEADBEEF;
        return 32'hA5000000 | 32'(a);
    endfunction

    // Arbitration rule: debug wins when alone, or on a round-robin tie when
    // the CPU was served last.
    function automatic logic pick_dbg(input logic c, input logic d, input logic last, input int fixed);
        if (!d) return 1'b0;
        if (!c) return 1'b1;
        if (fixed != 0) return 1'b0;
        return !last;
    endfunction

    // Cycle, counted from the grant, in which the ack is seen.
    function automatic int txn_cycles(input logic we);
        return we ? 2 : RD_LAT + 2;
    endfunction

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%0h required=%0h", nm, k, act, exp);
        end
    endtask

    task automatic chk_str(input string nm, input int k, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d actual=%s required=%s", nm, k, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_i ();

        logic [DW-1:0] ram [512];
        logic [DW-1:0] rd_q       = '0;
        logic          ram_loaded = 1'b0;

        assign bus_i.cpu_req   = cpu_req_s[gi];
        assign bus_i.cpu_we    = cpu_we_s[gi];
        assign bus_i.cpu_addr  = cpu_addr_s[gi];
        assign bus_i.cpu_wdata = cpu_wdata_s[gi];
        assign bus_i.dbg_req   = dbg_req_s[gi];
        assign bus_i.dbg_we    = dbg_we_s[gi];
        assign bus_i.dbg_addr  = dbg_addr_s[gi];
        assign bus_i.dbg_wdata = dbg_wdata_s[gi];
        assign bus_i.mem_rdata = rd_q;

        assign cpu_ack_w[gi]   = bus_i.cpu_ack;
        assign dbg_ack_w[gi]   = bus_i.dbg_ack;
        assign mem_en_w[gi]    = bus_i.mem_en;
        assign mem_we_w[gi]    = bus_i.mem_we;
        assign busy_w[gi]      = bus_i.busy;
        assign owner_w[gi]     = bus_i.owner;
        assign cpu_rdata_w[gi] = bus_i.cpu_rdata;
        assign dbg_rdata_w[gi] = bus_i.dbg_rdata;
        assign mem_addr_w[gi]  = bus_i.mem_addr;
        assign mem_wdata_w[gi] = bus_i.mem_wdata;

        mem_bus_arbiter #(
            .ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT), .FIXED_PRI(gi)
        ) u_dut (
            .clock (clock),
            .clear (clear_s[gi]),
            .bus   (bus_i)
        );

        // RAM macro with one cycle of read latency.
        always @(posedge clock) begin
            if (!ram_loaded) begin
                for (int a = 0; a < 512; a++) ram[a] <= init_word(a);
                ram_loaded <= 1'b1;
            end else if (bus_i.mem_en) begin
                if (bus_i.mem_we) ram[bus_i.mem_addr] <= bus_i.mem_wdata;
                else              rd_q <= ram[bus_i.mem_addr];
            end
        end

        // Model: m_phase counts cycles since the grant (0 = no transaction).
        int            m_phase;
        logic          m_owner, m_last, m_we;
        logic [AW-1:0] m_addr;
        logic [DW-1:0] m_wdata, m_cpu_rdata, m_dbg_rdata;
        logic [DW-1:0] m_ram [512];
        logic          m_loaded = 1'b0;

        always @(posedge clock or negedge clear_s[gi]) begin
            if (!clear_s[gi]) begin
                m_phase     <= 0;
                m_owner     <= 1'b0;
                m_last      <= 1'b1;
                m_we        <= 1'b0;
                m_addr      <= '0;
                m_wdata     <= '0;
                m_cpu_rdata <= '0;
                m_dbg_rdata <= '0;
            end else if (m_phase == 0) begin
                if (cpu_req_s[gi] || dbg_req_s[gi]) begin
                    m_owner <= pick_dbg(cpu_req_s[gi], dbg_req_s[gi], m_last, gi);
                    if (pick_dbg(cpu_req_s[gi], dbg_req_s[gi], m_last, gi)) begin
                        m_we <= dbg_we_s[gi]; m_addr <= dbg_addr_s[gi]; m_wdata <= dbg_wdata_s[gi];
                    end else begin
                        m_we <= cpu_we_s[gi]; m_addr <= cpu_addr_s[gi]; m_wdata <= cpu_wdata_s[gi];
                    end
                    m_phase <= 1;
                end
            end else if (m_phase == txn_cycles(m_we)) begin
                m_phase <= 0;
                m_last  <= m_owner;
            end else begin
                if (!m_we && m_phase + 1 == txn_cycles(m_we)) begin
                    if (m_owner) m_dbg_rdata <= m_ram[m_addr];
                    else         m_cpu_rdata <= m_ram[m_addr];
                end
                m_phase <= m_phase + 1;
            end
        end

        always @(posedge clock) begin
            if (!m_loaded) begin
                for (int a = 0; a < 512; a++) m_ram[a] <= init_word(a);
                m_loaded <= 1'b1;
            end else if (clear_s[gi] && m_phase == 1 && m_we) begin
                m_ram[m_addr] <= m_wdata;
            end
        end

        always @(negedge clock) begin
            chk("busy", gi, 64'(busy_w[gi]), 64'(m_phase != 0));
            chk("mem_en", gi, 64'(mem_en_w[gi]), 64'(m_phase == 1));
            chk("mem_we", gi, 64'(mem_we_w[gi]), 64'(m_phase == 1 && m_we));
            chk("cpu_ack", gi, 64'(cpu_ack_w[gi]),
                64'(m_phase != 0 && m_phase == txn_cycles(m_we) && !m_owner));
            chk("dbg_ack", gi, 64'(dbg_ack_w[gi]),
                64'(m_phase != 0 && m_phase == txn_cycles(m_we) && m_owner));
            chk("cpu_rdata", gi, 64'(cpu_rdata_w[gi]), 64'(m_cpu_rdata));
            chk("dbg_rdata", gi, 64'(dbg_rdata_w[gi]), 64'(m_dbg_rdata));
            if (m_phase != 0) chk("owner", gi, 64'(owner_w[gi]), 64'(m_owner));
            if (m_phase == 1) begin
                chk("mem_addr", gi, 64'(mem_addr_w[gi]), 64'(m_addr));
                if (m_we) chk("mem_wdata", gi, 64'(mem_wdata_w[gi]), 64'(m_wdata));
            end
        end
    end

    // Waits for n acks on instance k, logging C/D per ack; drop releases the
    // acked request at the edge that samples the ack.
    task automatic wait_acks(input int k, input int n, input bit drop, output int cycles);
        int got = 0;
        cycles = 0;
        while (got < n && cycles < 40) begin
            @(negedge clock);
            cycles++;
            if (cpu_ack_w[k]) begin
                log_s[k] = {log_s[k], "C"}; got++;
                if (drop) cpu_req_s[k] = 1'b0;
            end
            if (dbg_ack_w[k]) begin
                log_s[k] = {log_s[k], "D"}; got++;
                if (drop) dbg_req_s[k] = 1'b0;
            end
        end
        chk("ack_count", k, 64'(got), 64'(n));
    endtask

    initial begin
        int cyc;
        clear_s = 2'b00; cpu_req_s = 2'b00; dbg_req_s = 2'b00; cpu_we_s = 2'b00; dbg_we_s = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cpu_addr_s[k] = '0; dbg_addr_s[k] = '0; cpu_wdata_s[k] = '0; dbg_wdata_s[k] = '0;
            log_s[k] = "";
        end

        // 1: reset held with inputs toggling
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            cpu_req_s = 2'($urandom); dbg_req_s = 2'($urandom);
            cpu_we_s  = 2'($urandom); dbg_we_s  = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                cpu_addr_s[k] = AW'($urandom); dbg_addr_s[k] = AW'($urandom);
                cpu_wdata_s[k] = $urandom; dbg_wdata_s[k] = $urandom;
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk("rst_busy", k, 64'(busy_w[k]), 64'd0);
            chk("rst_mem_en", k, 64'(mem_en_w[k]), 64'd0);
            chk("rst_acks", k, 64'({cpu_ack_w[k], dbg_ack_w[k]}), 64'd0);
            chk("rst_cpu_rdata", k, 64'(cpu_rdata_w[k]), 64'd0);
            chk("rst_mem_addr", k, 64'(mem_addr_w[k]), 64'd0);
            chk("rst_mem_wdata", k, 64'(mem_wdata_w[k]), 64'd0);
            chk("rst_owner", k, 64'(owner_w[k]), 64'd0);
        end
        @(negedge clock);
        cpu_req_s = 2'b00; dbg_req_s = 2'b00;
        #2 clear_s = 2'b11;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) chk("idle_mem_en", k, 64'(mem_en_w[k]), 64'd0);

        // 2: CPU read of 0x010
        cpu_we_s[0] = 1'b0; cpu_addr_s[0] = 9'h010; cpu_req_s[0] = 1'b1;
        log_s[0] = "";
        wait_acks(0, 1, 1'b1, cyc);
        chk("t2_latency", 0, 64'(cyc), 64'd3);
        chk("t2_rdata", 0, 64'(cpu_rdata_w[0]), 64'h00000000DEADBEEF);
        chk_str("t2_grants", 0, log_s[0], "C");
        @(negedge clock);

        // 3: debug write then CPU read-back
        dbg_we_s[0] = 1'b1; dbg_addr_s[0] = 9'h020; dbg_wdata_s[0] = 32'h12345678; dbg_req_s[0] = 1'b1;
        wait_acks(0, 1, 1'b1, cyc);
        chk("t3_wr_latency", 0, 64'(cyc), 64'd2);
        chk("t3_dbg_rdata_kept", 0, 64'(dbg_rdata_w[0]), 64'd0);
        @(negedge clock);
        cpu_addr_s[0] = 9'h020; cpu_req_s[0] = 1'b1;
        wait_acks(0, 1, 1'b1, cyc);
        chk("t3_rd_latency", 0, 64'(cyc), 64'd3);
        chk("t3_rdata", 0, 64'(cpu_rdata_w[0]), 64'h0000000012345678);
        @(negedge clock);
        // debug read, leaving the debug port as last owner
        dbg_we_s[0] = 1'b0; dbg_addr_s[0] = 9'h010; dbg_req_s[0] = 1'b1;
        wait_acks(0, 1, 1'b1, cyc);
        chk("t3_dbg_rdata", 0, 64'(dbg_rdata_w[0]), 64'h00000000DEADBEEF);
        chk("t3_cpu_rdata_kept", 0, 64'(cpu_rdata_w[0]), 64'h0000000012345678);
        @(negedge clock);

        // 4: round-robin under constant contention
        log_s[0] = "";
        cpu_we_s[0] = 1'b0; cpu_addr_s[0] = 9'h010;
        dbg_we_s[0] = 1'b0; dbg_addr_s[0] = 9'h020;
        cpu_req_s[0] = 1'b1; dbg_req_s[0] = 1'b1;
        wait_acks(0, 6, 1'b0, cyc);
        cpu_req_s[0] = 1'b0; dbg_req_s[0] = 1'b0;
        chk_str("t4_grants", 0, log_s[0], "CDCDCD");
        @(negedge clock);

        // 5: fixed priority
        log_s[1] = "";
        cpu_we_s[1] = 1'b1; cpu_addr_s[1] = 9'h030; cpu_wdata_s[1] = 32'hCAFEF00D;
        dbg_we_s[1] = 1'b0; dbg_addr_s[1] = 9'h030;
        cpu_req_s[1] = 1'b1; dbg_req_s[1] = 1'b1;
        wait_acks(1, 3, 1'b0, cyc);
        cpu_req_s[1] = 1'b0;
        wait_acks(1, 1, 1'b1, cyc);
        chk_str("t5_grants", 1, log_s[1], "CCCD");
        chk("t5_dbg_rdata", 1, 64'(dbg_rdata_w[1]), 64'h00000000CAFEF00D);
        @(negedge clock);

        // 6: reset during WAIT of a CPU read, then re-issue
        log_s[0] = "";
        cpu_we_s[0] = 1'b0; cpu_addr_s[0] = 9'h010; cpu_req_s[0] = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("t6_in_wait", 0, 64'(busy_w[0]), 64'd1);
        #2 clear_s[0] = 1'b0;
        #1;
        chk("t6_rst_mem_en", 0, 64'(mem_en_w[0]), 64'd0);
        chk("t6_rst_busy", 0, 64'(busy_w[0]), 64'd0);
        @(negedge clock);
        chk("t6_no_ack", 0, 64'(cpu_ack_w[0]), 64'd0);
        #2 clear_s[0] = 1'b1;
        wait_acks(0, 1, 1'b1, cyc);
        chk("t6_latency", 0, 64'(cyc), 64'd3);
        chk("t6_rdata", 0, 64'(cpu_rdata_w[0]), 64'h00000000DEADBEEF);
        chk_str("t6_grants", 0, log_s[0], "C");

        repeat (3) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
